// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter for two requesters that share one serial shift register.
// Each winner's word is serialised onto sr_d over MSB cycles, then acknowledged with a done pulse.
module shift_arb_ctrl #(
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic           dir0,
  input  logic           dir1,
  input  logic [MSB-1:0] data0,
  input  logic [MSB-1:0] data1,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic           busy,
  output logic           sr_en,
  output logic           sr_dir,
  output logic           sr_d
);

  localparam int CW = $clog2(MSB) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MSB-1:0] data_q, data_d;
  logic           dir_q, dir_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           last_q, last_d;
  logic           win_s;
  logic [CW-1:0]  bit_idx_s;
  logic           bit_s;

  // Arbitration: a lone request wins; on a tie the requester not served last wins.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      win_s = ~last_q;
    end else begin
      win_s = req1;
    end
  end

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_SHIFT;
          cnt_d   = {CW{1'b0}};
          last_d  = win_s;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          dir_d   = win_s ? dir1 : dir0;
          data_d  = win_s ? data1 : data0;
        end else begin
          gnt_d = 2'b00;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(MSB - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      data_q  <= {MSB{1'b0}};
      dir_q   <= 1'b0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Left shifts take the word MSB-first, right shifts LSB-first, so the register ends up holding it.
  always_comb begin
    bit_s = 1'b0;
    if (dir_q) begin
      bit_idx_s = cnt_q;
    end else begin
      bit_idx_s = CW'(MSB - 1) - cnt_q;
    end
    for (int i = 0; i < MSB; i++) begin
      bit_s = bit_s | (data_q[i] & (bit_idx_s == CW'(i)));
    end
  end

  // Output decode from registered state.
  always_comb begin
    gnt    = gnt_q;
    busy   = (state_q != S_IDLE);
    sr_en  = (state_q == S_SHIFT);
    sr_dir = sr_en & dir_q;
    sr_d   = sr_en & bit_s;
    if (state_q == S_DONE) begin
      done = gnt_q;
    end else begin
      done = 2'b00;
    end
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: directed scenarios plus random traffic, checked against a
// transaction-level model that schedules each transfer's expected outputs in a queue.
module tb_shift_arb_ctrl;

  localparam int MSB = 4;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       en;
    logic       dir;
    logic       d;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, req0, req1, dir0, dir1;
  logic [MSB-1:0] data0, data1;
  logic [1:0]     gnt, done;
  logic           busy, sr_en, sr_dir, sr_d;

  int n_cmp = 0;
  int n_mis = 0;

  exp_t           exp_q[$];
  exp_t           cur;
  logic           last_srv;
  logic [MSB-1:0] sreg, lat_data;
  logic           prev_en, prev_dir, prev_d;
  logic [1:0]     prev_gnt;
  logic [1:0]     g_seen[$];

  shift_arb_ctrl #(.MSB(MSB)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
    .data0(data0), .data1(data1), .gnt(gnt), .done(done), .busy(busy),
    .sr_en(sr_en), .sr_dir(sr_dir), .sr_d(sr_d)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: on a grant, enqueue the whole transfer's expected outputs.
  task automatic model_edge();
    logic           w, d;
    logic [MSB-1:0] dat;
    logic [1:0]     g;
    if (rst) begin
      exp_q.delete();
      cur      = '0;
      last_srv = 1'b1;
      sreg     = '0;
    end else begin
      if (prev_en) begin
        if (prev_dir) sreg = {prev_d, sreg[MSB-1:1]};
        else          sreg = {sreg[MSB-2:0], prev_d};
      end
      if (!cur.busy && (req0 || req1)) begin
        w        = (req0 && req1) ? ~last_srv : req1;
        last_srv = w;
        g        = w ? 2'b10 : 2'b01;
        d        = w ? dir1 : dir0;
        dat      = w ? data1 : data0;
        lat_data = dat;
        sreg     = '0;
        for (int k = 0; k < MSB; k++) begin
          exp_q.push_back('{gnt: g, done: 2'b00, busy: 1'b1, en: 1'b1, dir: d,
                            d: (d ? dat[k] : dat[MSB-1-k])});
        end
        exp_q.push_back('{gnt: g, done: g, busy: 1'b1, en: 1'b0, dir: 1'b0, d: 1'b0});
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else                  cur = '0;
    end
  endtask

  task automatic step();
    exp_t obs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    obs = '{gnt: gnt, done: done, busy: busy, en: sr_en, dir: sr_dir, d: sr_d};
    check_val("outputs", 32'(obs), 32'(cur));
    check_val("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check_val("done_onehot", 32'($countones(done) <= 1), 32'd1);
    check_val("en_rule", 32'(!sr_en || (busy && done == 2'b00)), 32'd1);
    if (cur.done != 2'b00) check_val("sreg_final", 32'(sreg), 32'(lat_data));
    if (prev_gnt == 2'b00 && gnt != 2'b00) g_seen.push_back(gnt);
    prev_en  = sr_en;
    prev_dir = sr_dir;
    prev_d   = sr_d;
    prev_gnt = gnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [1:0] rr_exp[3];
    rr_exp = '{2'b01, 2'b10, 2'b01};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dir0 = 1'b0; dir1 = 1'b0;
    data0 = '0; data1 = '0;
    cur = '0; last_srv = 1'b1; sreg = '0; lat_data = '0;
    prev_en = 1'b0; prev_dir = 1'b0; prev_d = 1'b0; prev_gnt = 2'b00;
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(1);

    // Requester 0, left shift, 1011
    req0 = 1'b1; dir0 = 1'b0; data0 = 4'b1011;
    step();
    req0 = 1'b0;
    run(8);

    // Requester 1, right shift, 0110
    req1 = 1'b1; dir1 = 1'b1; data1 = 4'b0110;
    step();
    req1 = 1'b0;
    run(8);

    // Both held from reset release: grants alternate 01, 10, 01
    rst = 1'b1;
    step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    dir0 = 1'b0; data0 = 4'b1100; dir1 = 1'b1; data1 = 4'b0011;
    g_seen.delete();
    run(18);
    check_val("rr_count", 32'(g_seen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check_val("rr_seq", 32'((i < g_seen.size()) ? g_seen[i] : 2'b00), 32'(rr_exp[i]));
    req0 = 1'b0; req1 = 1'b0;
    run(8);

    // Reset on the third shift cycle aborts; next tie goes to requester 0
    req1 = 1'b1; dir1 = 1'b0; data1 = 4'b1001;
    step();
    req1 = 1'b0;
    run(2);
    rst = 1'b1;
    step();
    check_val("abort_gnt", 32'(gnt), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    step();
    check_val("rr_after_rst", 32'(gnt), 32'(2'b01));
    req0 = 1'b0; req1 = 1'b0;
    run(8);

    // Drop req and change data mid-transfer
    req0 = 1'b1; dir0 = 1'b0; data0 = 4'b1011;
    step();
    step();
    req0 = 1'b0; data0 = 4'b0100; dir0 = 1'b1;
    run(8);

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      dir0  = 1'($urandom);
      dir1  = 1'($urandom);
      data0 = MSB'($urandom);
      data1 = MSB'($urandom);
      step();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 Parameter MSB, default 4, gives the width of the attached shift register; legal values are MSB >= 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Ports req0 and req1, input, 1 bit each: transfer request from requester 0 and requester 1.
REQ-005 Ports dir0 and dir1, input, 1 bit each: requested shift direction (0 = left, 1 = right).
REQ-006 Ports data0 and data1, input, MSB bits each: word to be loaded serially into the shift register.
REQ-007 Port gnt, output, 2 bits: one-hot grant; bit i is high while requester i owns the register.
REQ-008 Port done, output, 2 bits: one-cycle completion pulse; bit i marks the end of requester i's transfer.
REQ-009 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 Ports sr_en, sr_dir and sr_d, output, 1 bit each: en, dir and d drive signals for the attached shift register.

Function
REQ-011 The block SHALL implement a state machine with three states (IDLE, SHIFT, DONE) and a bit counter of width clog2(MSB)+1.
REQ-012 In IDLE with any req high at a clock edge, the block SHALL, at that edge:
  - move to SHIFT;
  - latch the winner's dir and data;
  - set gnt to the winner;
  - clear the bit counter.
REQ-013 Arbitration SHALL be round-robin with a last-served pointer:
  - with one request, that requester wins;
  - with both requests, the requester not last served wins;
  - after reset, the pointer SHALL favour requester 0.
REQ-014 In SHIFT, the block SHALL hold sr_en=1 and sr_dir=latched dir for exactly MSB consecutive cycles.
REQ-015 The bit on sr_d SHALL be chosen by the latched direction:
  - dir=0: data sent MSB-first (bit MSB-1 first);
  - dir=1: data sent LSB-first (bit 0 first).
  In both cases, a cleared register SHALL hold exactly the latched data after the transfer.
REQ-016 After the MSB-th shift cycle, the block SHALL move to DONE for exactly one cycle:
  - done[i] = 1 for the granted requester i;
  - gnt remains asserted;
  - sr_en = 0.
REQ-017 DONE SHALL always move to IDLE, and gnt SHALL clear on entry to IDLE.
REQ-018 The block SHALL sample no request in DONE; a request still high in IDLE starts a new transfer, giving MSB+2 cycles per transfer.
REQ-019 Changes to req, dir or data after the latch edge SHALL have no effect; a requester dropping req mid-SHIFT SHALL NOT abort the transfer.
REQ-020 Outside SHIFT, sr_en SHALL be 0, and sr_d and sr_dir SHALL be 0.
REQ-021 gnt and done SHALL never have more than one bit set.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL:
  - enter IDLE;
  - clear the counter and latched data and direction;
  - reset the pointer;
  - drive gnt=00, done=00, busy=0, sr_en=0, sr_dir=0, sr_d=0.
REQ-023 Reset SHALL take priority over all other events, including mid-SHIFT, and no done pulse SHALL follow an aborted transfer.

Verification
REQ-024 With MSB=4, req0 only, dir0=0, data0=1011:
  - sr_d = 1,0,1,1 over 4 sr_en cycles, with sr_dir=0 and gnt=01;
  - done=01 for one cycle;
  - a model register starting at 0000 ends at 1011.
REQ-025 With req1 only, dir1=1, data1=0110:
  - sr_d = 0,1,1,0 with sr_dir=1 and gnt=10;
  - the model register ends at 0110;
  - done=10 for one cycle.
REQ-026 With req0 and req1 both held high from reset release: grants SHALL be 01, 10, 01, each transfer 6 cycles long, with one IDLE cycle between transfers.
REQ-027 With rst=1 on the 3rd SHIFT cycle: on the next cycle gnt=00, busy=0 and sr_en=0; no done follows; a following simultaneous request SHALL be granted to requester 0.
REQ-028 With req0 dropped and data0 changed on the 2nd SHIFT cycle: the original bits still shift out and done=01 pulses.
REQ-029 The bench SHALL check throughout that gnt and done are never multi-hot, and that sr_en is high only while busy is high and done is 0.
